mem_ctrl: RTL and testbench

- Memory-side responder for the instruction fetcher and the load/store queue.
- Accepts one-cycle request pulses from each requester and buffers them in one pending slot per requester.
- Arbitrates between requests and serialises each into byte-wide accesses on the 8-bit RAM bus.
- Assembles read data little-endian and returns it with a one-cycle ready pulse.
- Cancels speculative fetches and loads on rollback; committed stores always complete.

---
 rtl/mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM responder for fetch and load/store.
// One pending slot per requester, LS priority, rollback aware.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_rollback,
  input  logic                    in_if_ena,
  input  logic [ADDR_WIDTH-1:0]   in_if_addr,
  output logic                    out_if_ready,
  output logic [8*WORD_BYTES-1:0] out_if_inst,
  input  logic                    in_ls_ena,
  input  logic                    in_ls_iswrite,
  input  logic [1:0]              in_ls_size,
  input  logic [ADDR_WIDTH-1:0]   in_ls_addr,
  input  logic [8*WORD_BYTES-1:0] in_ls_data,
  output logic                    out_ls_ready,
  output logic [8*WORD_BYTES-1:0] out_ls_data,
  input  logic [7:0]              in_ram_data,
  output logic [7:0]              out_ram_data,
  output logic [ADDR_WIDTH-1:0]   out_ram_addr,
  output logic                    out_ram_wr
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                r_state, w_state_n;

  logic                  r_if_v, w_if_v_n;
  logic [ADDR_WIDTH-1:0] r_if_addr, w_if_addr_n;

  logic                  r_ls_v, w_ls_v_n;
  logic                  r_ls_wr, w_ls_wr_n;
  logic [1:0]            r_ls_size, w_ls_size_n;
  logic [ADDR_WIDTH-1:0] r_ls_addr, w_ls_addr_n;
  logic [DW-1:0]         r_ls_data, w_ls_data_n;

  logic                  r_cur_ls, w_cur_ls_n;
  logic                  r_cur_wr, w_cur_wr_n;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  logic [CW-1:0]         r_nb, w_nb_n;
  logic [DW-1:0]         r_wdata, w_wdata_n;
  logic [DW-1:0]         r_buf, w_buf_n;

  logic                  r_if_ready, w_if_ready_n;
  logic [DW-1:0]         r_if_inst, w_if_inst_n;
  logic                  r_ls_ready, w_ls_ready_n;
  logic [DW-1:0]         r_ls_rdata, w_ls_rdata_n;
  logic [7:0]            r_ram_data, w_ram_data_n;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_n;
  logic                  r_ram_wr, w_ram_wr_n;

  // A rollback cancels speculative live requests; stores survive it.
  logic                  w_if_live, w_ls_live;
  logic                  w_if_req, w_ls_req;
  logic                  w_sel_wr;
  logic [1:0]            w_sel_size;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DW-1:0]         w_sel_data;
  logic [CW-1:0]         w_ls_nb;
  logic [DW-1:0]         w_cap;

  assign w_if_live = in_if_ena & ~in_rollback;
  assign w_ls_live = in_ls_ena & ~(in_rollback & ~in_ls_iswrite);
  assign w_if_req  = w_if_live | (r_if_v & ~in_rollback);
  assign w_ls_req  = w_ls_live | (r_ls_v & ~(in_rollback & ~r_ls_wr));

  assign w_sel_wr   = w_ls_live ? in_ls_iswrite : r_ls_wr;
  assign w_sel_size = w_ls_live ? in_ls_size    : r_ls_size;
  assign w_sel_addr = w_ls_live ? in_ls_addr    : r_ls_addr;
  assign w_sel_data = w_ls_live ? in_ls_data    : r_ls_data;

  // Transfer length in bytes for the selected LS request.
  always_comb begin
    w_ls_nb = CW'(WORD_BYTES);
    unique case (w_sel_size)
      2'd0:    w_ls_nb = CW'(1);
      2'd1:    w_ls_nb = CW'(2);
      default: w_ls_nb = CW'(WORD_BYTES);
    endcase
  end

  // Merge the byte on the RAM bus into its little-endian lane.
  always_comb begin
    w_cap = r_buf;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (r_cnt == CW'(b + 1)) begin
        w_cap[8*b +: 8] = in_ram_data;
      end
    end
  end

  // Next-state, slot and output computation.
  always_comb begin
    w_state_n    = r_state;
    w_if_v_n     = r_if_v;
    w_if_addr_n  = r_if_addr;
    w_ls_v_n     = r_ls_v;
    w_ls_wr_n    = r_ls_wr;
    w_ls_size_n  = r_ls_size;
    w_ls_addr_n  = r_ls_addr;
    w_ls_data_n  = r_ls_data;
    w_cur_ls_n   = r_cur_ls;
    w_cur_wr_n   = r_cur_wr;
    w_cnt_n      = r_cnt;
    w_nb_n       = r_nb;
    w_wdata_n    = r_wdata;
    w_buf_n      = r_buf;
    w_if_ready_n = 1'b0;
    w_if_inst_n  = r_if_inst;
    w_ls_ready_n = 1'b0;
    w_ls_rdata_n = r_ls_rdata;
    w_ram_data_n = r_ram_data;
    w_ram_addr_n = r_ram_addr;
    w_ram_wr_n   = r_ram_wr;

    if (in_rollback) begin
      w_if_v_n = 1'b0;
      if (!r_ls_wr) w_ls_v_n = 1'b0;
    end
    if (w_if_live) begin
      w_if_v_n    = 1'b1;
      w_if_addr_n = in_if_addr;
    end
    if (w_ls_live) begin
      w_ls_v_n    = 1'b1;
      w_ls_wr_n   = in_ls_iswrite;
      w_ls_size_n = in_ls_size;
      w_ls_addr_n = in_ls_addr;
      w_ls_data_n = in_ls_data;
    end

    unique case (r_state)
      IDLE: begin
        if (w_ls_req) begin
          w_ls_v_n     = 1'b0;
          w_state_n    = XFER;
          w_cur_ls_n   = 1'b1;
          w_cur_wr_n   = w_sel_wr;
          w_cnt_n      = '0;
          w_nb_n       = w_ls_nb;
          w_wdata_n    = w_sel_data;
          w_buf_n      = '0;
          w_ram_addr_n = w_sel_addr;
          w_ram_data_n = w_sel_data[7:0];
          w_ram_wr_n   = w_sel_wr;
        end else if (w_if_req) begin
          w_if_v_n     = 1'b0;
          w_state_n    = XFER;
          w_cur_ls_n   = 1'b0;
          w_cur_wr_n   = 1'b0;
          w_cnt_n      = '0;
          w_nb_n       = CW'(WORD_BYTES);
          w_wdata_n    = '0;
          w_buf_n      = '0;
          w_ram_addr_n = w_if_live ? in_if_addr : r_if_addr;
          w_ram_data_n = '0;
          w_ram_wr_n   = 1'b0;
        end
      end
      XFER: begin
        if (in_rollback && !r_cur_wr) begin
          w_state_n  = IDLE;
          w_ram_wr_n = 1'b0;
        end else if (r_cur_wr) begin
          if ((r_cnt + CW'(1)) < r_nb) begin
            w_cnt_n      = r_cnt + CW'(1);
            w_ram_addr_n = r_ram_addr + 1'b1;
            w_wdata_n    = r_wdata >> 8;
            w_ram_data_n = r_wdata[15:8];
          end else begin
            w_ram_wr_n   = 1'b0;
            w_ls_ready_n = 1'b1;
            w_state_n    = IDLE;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
          w_buf_n = w_cap;
          if ((r_cnt + CW'(1)) < r_nb) begin
            w_ram_addr_n = r_ram_addr + 1'b1;
          end
          if (r_cnt == r_nb) begin
            w_state_n = IDLE;
            if (r_cur_ls) begin
              w_ls_ready_n = 1'b1;
              w_ls_rdata_n = w_cap;
            end else begin
              w_if_ready_n = 1'b1;
              w_if_inst_n  = w_cap;
            end
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_if_v     <= 1'b0;
      r_if_addr  <= '0;
      r_ls_v     <= 1'b0;
      r_ls_wr    <= 1'b0;
      r_ls_size  <= '0;
      r_ls_addr  <= '0;
      r_ls_data  <= '0;
      r_cur_ls   <= 1'b0;
      r_cur_wr   <= 1'b0;
      r_cnt      <= '0;
      r_nb       <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_if_ready <= 1'b0;
      r_if_inst  <= '0;
      r_ls_ready <= 1'b0;
      r_ls_rdata <= '0;
      r_ram_data <= '0;
      r_ram_addr <= '0;
      r_ram_wr   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_if_v     <= w_if_v_n;
      r_if_addr  <= w_if_addr_n;
      r_ls_v     <= w_ls_v_n;
      r_ls_wr    <= w_ls_wr_n;
      r_ls_size  <= w_ls_size_n;
      r_ls_addr  <= w_ls_addr_n;
      r_ls_data  <= w_ls_data_n;
      r_cur_ls   <= w_cur_ls_n;
      r_cur_wr   <= w_cur_wr_n;
      r_cnt      <= w_cnt_n;
      r_nb       <= w_nb_n;
      r_wdata    <= w_wdata_n;
      r_buf      <= w_buf_n;
      r_if_ready <= w_if_ready_n;
      r_if_inst  <= w_if_inst_n;
      r_ls_ready <= w_ls_ready_n;
      r_ls_rdata <= w_ls_rdata_n;
      r_ram_data <= w_ram_data_n;
      r_ram_addr <= w_ram_addr_n;
      r_ram_wr   <= w_ram_wr_n;
    end
  end

  assign out_if_ready = r_if_ready;
  assign out_if_inst  = r_if_inst;
  assign out_ls_ready = r_ls_ready;
  assign out_ls_data  = r_ls_rdata;
  assign out_ram_data = r_ram_data;
  assign out_ram_addr = r_ram_addr;
  assign out_ram_wr   = r_ram_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a
// registered byte RAM preloaded with known patterns.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rollback;
  logic        in_if_ena;
  logic [31:0] in_if_addr;
  logic        out_if_ready;
  logic [31:0] out_if_inst;
  logic        in_ls_ena;
  logic        in_ls_iswrite;
  logic [1:0]  in_ls_size;
  logic [31:0] in_ls_addr;
  logic [31:0] in_ls_data;
  logic        out_ls_ready;
  logic [31:0] out_ls_data;
  logic [7:0]  in_ram_data;
  logic [7:0]  out_ram_data;
  logic [31:0] out_ram_addr;
  logic        out_ram_wr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:65535];
  logic [31:0] sd;

  mem_ctrl #(.ADDR_WIDTH(32), .WORD_BYTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_rollback  (in_rollback),
    .in_if_ena    (in_if_ena),
    .in_if_addr   (in_if_addr),
    .out_if_ready (out_if_ready),
    .out_if_inst  (out_if_inst),
    .in_ls_ena    (in_ls_ena),
    .in_ls_iswrite(in_ls_iswrite),
    .in_ls_size   (in_ls_size),
    .in_ls_addr   (in_ls_addr),
    .in_ls_data   (in_ls_data),
    .out_ls_ready (out_ls_ready),
    .out_ls_data  (out_ls_data),
    .in_ram_data  (in_ram_data),
    .out_ram_data (out_ram_data),
    .out_ram_addr (out_ram_addr),
    .out_ram_wr   (out_ram_wr)
  );

  always #5 clk = ~clk;

  // Read data returns one cycle after the address.
  always @(posedge clk) begin
    in_ram_data <= mem[out_ram_addr[15:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1000] = 8'h13;
    mem[16'h0020] = 8'hAA; mem[16'h0021] = 8'hBB;
    mem[16'h0022] = 8'hCC; mem[16'h0023] = 8'hDD;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    mem[16'h0040] = 8'h01; mem[16'h0041] = 8'h02;
    mem[16'h0042] = 8'h03; mem[16'h0043] = 8'h04;
    mem[16'hFFFE] = 8'h5A; mem[16'hFFFF] = 8'h6B;
    mem[16'h0000] = 8'h7C; mem[16'h0001] = 8'h8D;

    rst = 1'b1; in_rollback = 1'b0;
    in_if_ena = 1'b0; in_if_addr = '0;
    in_ls_ena = 1'b0; in_ls_iswrite = 1'b0;
    in_ls_size = '0; in_ls_addr = '0; in_ls_data = '0;
    tick(); tick(); tick();
    rst = 1'b0;

    // reset then idle
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("rst_outs", {out_if_ready, out_if_inst, out_ls_ready,
          out_ls_data, out_ram_data, out_ram_addr, out_ram_wr}, '0);
    end

    // fetch 0x1000
    in_if_ena = 1'b1; in_if_addr = 32'h1000;
    tick();
    in_if_ena = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      if (c <= 4) chk("f_addr", out_ram_addr, 32'h1000 + c - 1);
      chk("f_wr", out_ram_wr, 1'b0);
      chk("f_rdy", out_if_ready, c == 6);
      if (c == 6) chk("f_inst", out_if_inst, 32'h13);
    end

    // simultaneous fetch and word load: load first
    in_if_ena = 1'b1; in_if_addr = 32'h20;
    in_ls_ena = 1'b1; in_ls_iswrite = 1'b0;
    in_ls_size = 2'd2; in_ls_addr = 32'h100;
    tick();
    in_if_ena = 1'b0; in_ls_ena = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) tick();
      chk("arb_lsrdy", out_ls_ready, c == 6);
      chk("arb_ifrdy", out_if_ready, c == 12);
      chk("arb_wr", out_ram_wr, 1'b0);
      if (c == 1) chk("arb_addr1", out_ram_addr, 32'h100);
      if (c == 6) chk("arb_lsdata", out_ls_data, 32'h44332211);
      if (c >= 7 && c <= 10)
        chk("arb_faddr", out_ram_addr, 32'h20 + c - 7);
      if (c == 12) chk("arb_inst", out_if_inst, 32'hDDCCBBAA);
    end

    // half store 0xBEEF to 0x7
    in_ls_ena = 1'b1; in_ls_iswrite = 1'b1;
    in_ls_size = 2'd1; in_ls_addr = 32'h7; in_ls_data = 32'h0000BEEF;
    tick();
    in_ls_ena = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      chk("hs_wr", out_ram_wr, c <= 2);
      chk("hs_rdy", out_ls_ready, c == 3);
      if (c == 1) chk("hs_b0", {out_ram_addr, out_ram_data}, {32'h7, 8'hEF});
      if (c == 2) chk("hs_b1", {out_ram_addr, out_ram_data}, {32'h8, 8'hBE});
    end

    // fetch aborted by rollback, then a fresh fetch
    in_if_ena = 1'b1; in_if_addr = 32'h1000;
    tick();
    in_if_ena = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (c == 3) in_rollback = 1'b1;
      if (c == 4) in_rollback = 1'b0;
      if (c == 5) begin in_if_ena = 1'b1; in_if_addr = 32'h40; end
      if (c == 6) in_if_ena = 1'b0;
      chk("rb_rdy", out_if_ready, c == 11);
      chk("rb_wr", out_ram_wr, 1'b0);
      if (c >= 6 && c <= 9)
        chk("rb_addr", out_ram_addr, 32'h40 + c - 6);
      if (c == 11) chk("rb_inst", out_if_inst, 32'h04030201);
    end

    // word store survives rollback; pending fetch dropped
    sd = 32'hCAFEF00D;
    in_ls_ena = 1'b1; in_ls_iswrite = 1'b1;
    in_ls_size = 2'd2; in_ls_addr = 32'h200; in_ls_data = sd;
    in_if_ena = 1'b1; in_if_addr = 32'h1000;
    tick();
    in_ls_ena = 1'b0; in_if_ena = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (c == 2) in_rollback = 1'b1;
      if (c == 3) in_rollback = 1'b0;
      chk("ws_wr", out_ram_wr, c <= 4);
      chk("ws_rdy", out_ls_ready, c == 5);
      chk("ws_ifrdy", out_if_ready, 1'b0);
      if (c <= 4)
        chk("ws_byte", {out_ram_addr, out_ram_data},
            {32'h200 + c - 1, sd[8*(c-1) +: 8]});
      else
        chk("ws_hold", out_ram_addr, 32'h203);
    end

    // word load wrapping past the top of the address space
    in_ls_ena = 1'b1; in_ls_iswrite = 1'b0;
    in_ls_size = 2'd2; in_ls_addr = 32'hFFFF_FFFE;
    tick();
    in_ls_ena = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      if (c == 1) chk("wrap_a0", out_ram_addr, 32'hFFFF_FFFE);
      if (c == 2) chk("wrap_a1", out_ram_addr, 32'hFFFF_FFFF);
      if (c == 3) chk("wrap_a2", out_ram_addr, 32'h0);
      if (c == 4) chk("wrap_a3", out_ram_addr, 32'h1);
      chk("wrap_rdy", out_ls_ready, c == 6);
      if (c == 6) chk("wrap_data", out_ls_data, 32'h8D7C6B5A);
    end

    // byte load: zero-extended, ready in cycle 3
    in_ls_ena = 1'b1; in_ls_size = 2'd0; in_ls_addr = 32'h101;
    tick();
    in_ls_ena = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      chk("bl_rdy", out_ls_ready, c == 3);
      if (c == 3) chk("bl_data", out_ls_data, 32'h22);
    end

    // rollback on the final capture edge kills the load
    in_ls_ena = 1'b1; in_ls_size = 2'd0; in_ls_addr = 32'h102;
    tick();
    in_ls_ena = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      if (c == 2) in_rollback = 1'b1;
      if (c == 3) in_rollback = 1'b0;
      chk("rbl_rdy", out_ls_ready, 1'b0);
      if (c == 5) chk("rbl_data", out_ls_data, 32'h22);
    end

    // reset in the middle of a transfer
    in_ls_ena = 1'b1; in_ls_size = 2'd2; in_ls_addr = 32'h100;
    tick();
    in_ls_ena = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("mrst_outs", {out_if_ready, out_if_inst, out_ls_ready,
          out_ls_data, out_ram_data, out_ram_addr, out_ram_wr}, '0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
